qsn_unshift_fifo: RTL and testbench
===================================

# qsn_unshift_fifo

Inverse companion to the quasi-cyclic shift network in the LDPC datapath. It accepts LIFT-bit sub-blocks together with the cyclic shift applied to them on the forward path, and rotates each one back by that shift. The restored sub-blocks are buffered in a small FIFO with valid/ready handshakes on both sides. It sits between the check-node output of the QSN and the variable-node memory write port.

## Interface
- LIFT, 4, lifting factor Z; sub-block width in bits
- SHIFT_W, 2, shift field width; shift is taken modulo LIFT
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  producer has a sub-block
- in_ready  output  1  block can accept a sub-block this cycle
- in_data  input  LIFT  shifted sub-block (forward: out[i] = in[(i+s) mod LIFT])
- in_shift  input  SHIFT_W  forward shift s applied to in_data
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  consumer takes head this cycle
- out_data  output  LIFT  restored sub-block
- occupancy  output  log2(DEPTH)+1  entry count (only with QSN_UNSHIFT_OCC_EN)

## Operation
- Inverse rotation: r = in_shift mod LIFT; stored[i] = in_data[(i − r) mod LIFT], i.e. rotate toward MSB by r. r = 0 is pass-through.
- Push when in_valid && in_ready. The rotated word is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Pop when out_valid && out_ready. rd_ptr increments mod DEPTH.
- Count tracks occupancy 0..DEPTH:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged, both pointers advance.
- in_ready = (count < DEPTH). There is no pass-through when full: a push while full is never accepted, even if a pop occurs that cycle.
- out_valid = (count > 0). out_data = mem[rd_ptr], presented combinationally from the registered array.
- out_data is held stable while out_valid && !out_ready.
- When count == 0, out_data is don't-care; the bench must not check it.
- in_data and in_shift are ignored when in_valid = 0 or in_ready = 0.
- Pointer wrap-around is silent. Order is strictly FIFO.

## Timing
- Reset (async assert, sync-deasserted externally):
  - wr_ptr = rd_ptr = count = 0
  - out_valid = 0, in_ready = 1, occupancy = 0
  - memory contents are not reset.
- Latency: a word pushed in cycle n appears on out_data with out_valid = 1 in cycle n+1 if the FIFO was empty. Otherwise it appears after all earlier entries.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset asserted mid-operation: all entries are discarded immediately (async). out_valid falls in the same cycle as rst_n falls.
- in_ready and out_valid depend only on registered count. There are no combinational paths from in_valid or out_ready to them.

## Configuration
- QSN_UNSHIFT_OCC_EN:
  - When defined: the occupancy port exists and equals count, with reset value 0.
  - When undefined: the port is absent and behaviour is otherwise identical.

## Test plan
- Single word: reset, then push in_data = 4'b0001, in_shift = 1 → next cycle out_valid = 1, out_data = 4'b0010.
- Rotation sweep: push 4'b1011 with shifts 0,1,2,3 and keep out_ready = 1 → outputs 4'b1011, 4'b0111, 4'b1110, 4'b1101 in order, one cycle after each push.
- Full: out_ready = 0, push 4 words → in_ready = 0 after the 4th push. A 5th word held on in_valid is not accepted. Occupancy = 4 (OCC_EN).
- Simultaneous push/pop when full: in_ready = 0, so only the pop happens and count goes 4 → 3. Then with count = 2, push and pop together → count stays 2 and order is preserved.
- Wrap-around: push and pop 10 words with random shifts. Every output equals the forward-rotated input rotated back, and the pointers wrap cleanly.
- Reset mid-stream: with 3 entries, drop rst_n → out_valid = 0 and in_ready = 1 immediately. After release, the first push appears unaffected by stale data.

Source files
------------

// File: rtl/qsn_unshift_fifo.sv
// Inverse QSN rotation followed by a small valid/ready FIFO for the LDPC VN write path.
// Optional occupancy port enabled by defining QSN_UNSHIFT_OCC_EN.
module qsn_unshift_fifo #(
  parameter int LIFT    = 4,
  parameter int SHIFT_W = 2,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LIFT-1:0]    in_data,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LIFT-1:0]    out_data
`ifdef QSN_UNSHIFT_OCC_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [LIFT-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_s, pop_s;
  logic [LIFT-1:0]  wdata_s;

  // Undo the forward shift: bit i takes in bit (i - r) mod LIFT, i.e. rotate toward MSB.
  function automatic logic [LIFT-1:0] unshift(input logic [LIFT-1:0] d,
                                              input logic [SHIFT_W-1:0] s);
    logic [LIFT-1:0] res;
    int amt;
    amt = 32'(s) % LIFT;
    for (int i = 0; i < LIFT; i++) begin
      res[i] = d[(i + LIFT - amt) % LIFT];
    end
    return res;
  endfunction

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != {(PTR_W+1){1'b0}});
  assign out_data  = mem_q[rd_ptr_q];
`ifdef QSN_UNSHIFT_OCC_EN
  assign occupancy = count_q;
`endif

  // Handshake decode and next-state for pointers and count.
  always_comb begin
    push_s   = in_valid && in_ready;
    pop_s    = out_valid && out_ready;
    wdata_s  = unshift(in_data, in_shift);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO at once so out_valid drops with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is intentionally not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

endmodule

// File: tb/tb_qsn_unshift_fifo.sv
// Scoreboard bench for qsn_unshift_fifo: driver pushes expected words, a monitor pops and compares.
module tb_qsn_unshift_fifo;

  localparam int LIFT    = 4;
  localparam int SHIFT_W = 2;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [LIFT-1:0]    in_data;
  logic [SHIFT_W-1:0] in_shift;
  logic               out_valid;
  logic               out_ready;
  logic [LIFT-1:0]    out_data;
`ifdef QSN_UNSHIFT_OCC_EN
  logic [$clog2(DEPTH):0] occupancy;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;
  logic [LIFT-1:0] exp_q[$];

  qsn_unshift_fifo #(.LIFT(LIFT), .SHIFT_W(SHIFT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef QSN_UNSHIFT_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Reference: rotating left by r is the top half of {d,d} shifted left by r.
  function automatic logic [LIFT-1:0] ref_unshift(input logic [LIFT-1:0] d, input int s);
    logic [2*LIFT-1:0] w;
    int r;
    r = s % LIFT;
    w = {d, d} << r;
    return w[2*LIFT-1:LIFT];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  // One clock of stimulus; entered and left just after a rising edge.
  task automatic cycle(input logic v, input logic [LIFT-1:0] d,
                       input logic [SHIFT_W-1:0] s, input logic r);
    logic push, pop;
    in_valid  = v;
    in_data   = d;
    in_shift  = s;
    out_ready = r;
    @(negedge clk);
    check("in_ready", in_ready, model_cnt < DEPTH);
    push = v && (model_cnt < DEPTH);
    pop  = r && (model_cnt > 0);
    @(posedge clk);
    if (push) exp_q.push_back(ref_unshift(d, int'(s)));
    model_cnt = model_cnt + int'(push) - int'(pop);
    #1;
  endtask

  // Monitor: compares the head against the scoreboard whenever a pop is presented.
  initial begin
    logic [LIFT-1:0] w;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("out_valid", out_valid, exp_q.size() != 0);
`ifdef QSN_UNSHIFT_OCC_EN
        check("occupancy", occupancy, exp_q.size());
`endif
        if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("out_data", out_data, w);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef QSN_UNSHIFT_OCC_EN
    check("rst_occupancy", occupancy, 0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word
    cycle(1'b1, 4'b0001, 2'd1, 1'b0);
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 4'b0010);
    cycle(1'b0, 4'b0000, 2'd0, 1'b1);

    // Rotation sweep with a consumer that is always ready
    for (int sh = 0; sh < 4; sh++) cycle(1'b1, 4'b1011, SHIFT_W'(sh), 1'b1);
    cycle(1'b0, 4'b0000, 2'd0, 1'b1);

    // Fill, then offer a fifth word that must be refused
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, LIFT'($urandom), SHIFT_W'($urandom), 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    cycle(1'b1, 4'b1111, 2'd3, 1'b0);
    // Push+pop while full: only the pop lands
    cycle(1'b1, 4'b1010, 2'd1, 1'b1);
    check("after_full_pop_ready", in_ready, 1'b1);
    cycle(1'b0, 4'b0000, 2'd0, 1'b1);
    cycle(1'b1, 4'b0101, 2'd2, 1'b1);
    cycle(1'b1, 4'b1100, 2'd3, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0000, 2'd0, 1'b1);

    // Wrap-around with random shifts
    for (int k = 0; k < 10; k++) cycle(1'b1, LIFT'($urandom), SHIFT_W'($urandom), 1'b1);
    cycle(1'b0, 4'b0000, 2'd0, 1'b1);

    // Reset mid-stream with three entries held
    for (int k = 0; k < 3; k++) cycle(1'b1, LIFT'($urandom), SHIFT_W'($urandom), 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
`ifdef QSN_UNSHIFT_OCC_EN
    check("midrst_occupancy", occupancy, 0);
`endif
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b1, 4'b0110, 2'd2, 1'b0);
    check("post_rst_data", out_data, 4'b1001);
    cycle(1'b0, 4'b0000, 2'd0, 1'b1);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), LIFT'($urandom), SHIFT_W'($urandom),
            1'($urandom_range(0, 3) != 0 ? 1 : 0));
    end

    // Bounded drain
    for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, 4'b0000, 2'd0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
